// File: rtl/otprom_ram_resp.sv
// otprom_ram_resp: one-time-programmable PROM responder on the s_ram_* interface.
// Reads return stored words one cycle after acceptance. Writes OR the supplied
// bits into the addressed word after a PROG_CYCLES-long program pulse, so bits
// can only go 0->1. The array has no reset: its contents survive reset.
// Optional feature: define OTPROM_WRITE_LOCK_EN to make bit 0 of word DEPTH-1
// a lock fuse. Once that bit is blown, every write is rejected with err.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready=1, accepting reads and writes
// PROG  | program pulse running, counter counts down to 0, then fuses blow
// DONE  | one-cycle wdone pulse, ready still low

module otprom_ram_resp #(
    parameter int DEPTH       = 64,
    parameter int AW          = 6,
    parameter int PROG_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] s_ram_raddr,
    input  logic        s_ram_ren,
    output logic [31:0] s_ram_rdata,
    output logic        s_ram_rvalid,
    input  logic [31:0] s_ram_waddr,
    input  logic [31:0] s_ram_wdata,
    input  logic        s_ram_wen,
    output logic        s_ram_ready,
    output logic        s_ram_wdone,
    output logic        s_ram_err
);

    localparam int CW = $clog2(PROG_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROG = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] widx_q;
    logic [31:0]   wdat_q;
    logic [31:0]   rdata_q;
    logic          rvalid_q;
    logic          wdone_q;
    logic          err_q;
    logic          ready_q;

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] r_idx;
    logic [AW-1:0] w_idx;
    logic          r_in_range;
    logic          w_in_range;
    logic          locked;
    logic          idle;
    logic          prog_fire;
    logic          unused_addr_bits;

    assign r_idx      = s_ram_raddr[AW+1:2];
    assign w_idx      = s_ram_waddr[AW+1:2];
    assign r_in_range = (s_ram_raddr[31:AW+2] == '0);
    assign w_in_range = (s_ram_waddr[31:AW+2] == '0);
    assign idle       = (state_q == IDLE);
    assign prog_fire  = (state_q == PROG) && (cnt_q == '0);

    // Byte-lane bits of the addresses carry no meaning for a word array.
    assign unused_addr_bits = ^{s_ram_raddr[1:0], s_ram_waddr[1:0]};

`ifdef OTPROM_WRITE_LOCK_EN
    assign locked = mem_q[DEPTH-1][0];
`else
    assign locked = 1'b0;
`endif

    // Request handling, program-pulse sequencing and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            widx_q   <= '0;
            wdat_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A same-cycle write only lands after the pulse, so this
                    // read sees the pre-program contents.
                    if (s_ram_ren) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= r_in_range ? mem_q[r_idx] : 32'h0;
                    end
                    err_q <= (s_ram_ren && !r_in_range) ||
                             (s_ram_wen && (!w_in_range || locked));
                    if (s_ram_wen && w_in_range && !locked) begin
                        widx_q  <= w_idx;
                        wdat_q  <= s_ram_wdata;
                        cnt_q   <= CW'(PROG_CYCLES - 1);
                        state_q <= PROG;
                        ready_q <= 1'b0;
                    end
                end
                PROG: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                        wdone_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Fuse array: never reset, only ORs bits in at the end of a pulse.
    always_ff @(posedge clk) begin
        if (!reset && prog_fire) begin
            mem_q[widx_q] <= mem_q[widx_q] | wdat_q;
        end
    end

    assign s_ram_rdata  = rdata_q;
    assign s_ram_rvalid = rvalid_q;
    assign s_ram_wdone  = wdone_q;
    assign s_ram_err    = err_q;
    assign s_ram_ready  = ready_q;

endmodule

// File: doc/otprom_ram_resp.md
Name: otprom_ram_resp

Overview:
- Responder end of the m_ram_* master interface driven by top.
- Models a one-time-programmable PROM array behind that interface: reads return stored words; writes "blow fuses" (bits can only go 0->1) over a multi-cycle program pulse.
- Sits under top as the memory target, so the bench can run real m_ram_* traffic instead of forcing it idle.

Parameters:
- DEPTH, 64, number of 32-bit words in the array (power of 2).
- AW, 6, word-address width, log2(DEPTH).
- PROG_CYCLES, 8, cycles a program pulse lasts (>=2).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_ram_raddr  in  32  byte read address; word index = raddr[AW+1:2].
- s_ram_ren  in  1  read request, accepted when s_ram_ready=1.
- s_ram_rdata  out  32  read data, valid while s_ram_rvalid=1.
- s_ram_rvalid  out  1  one-cycle pulse, read data valid.
- s_ram_waddr  in  32  byte write address.
- s_ram_wdata  in  32  bits to program (1 = blow fuse).
- s_ram_wen  in  1  write request, accepted when s_ram_ready=1.
- s_ram_ready  out  1  responder can accept a request this cycle.
- s_ram_wdone  out  1  one-cycle pulse, program pulse finished.
- s_ram_err  out  1  one-cycle pulse, request rejected (range/lock).

Behaviour:
- Reset: s_ram_rdata=0, rvalid=0, wdone=0, err=0, ready=1, FSM=IDLE, pulse counter=0. Array contents are NOT cleared by reset (non-volatile); at time zero all words are 0 (unprogrammed).
- Range: address in range iff addr[31:AW+2]==0. addr[1:0] ignored.
- FSM states: IDLE, PROG, DONE.
  - IDLE: ready=1.
  - Accepted wen, in range: latch word index and wdata, go to PROG, counter=PROG_CYCLES-1.
  - Accepted wen, out of range: err pulse next cycle, stay IDLE.
  - PROG: ready=0. Counter decrements each cycle. At 0: word <= word | wdata_latched, go to DONE.
  - DONE: wdone=1 for one cycle, ready=0, then IDLE.
- Write accept to wdone = PROG_CYCLES+1 cycles. ready is low from the cycle after accept through the DONE cycle.
- Read latency is 1 cycle: rdata/rvalid registered the cycle after an accepted ren.
  - Out-of-range read returns rdata=0, rvalid=1, err=1 in the same cycle.
  - rdata holds its last value when rvalid=0.
- ren and wen in the same IDLE cycle: both accepted. The read returns the pre-program contents; the write proceeds normally.
- ren or wen while ready=0: ignored, with no err and no side effect. The master must hold or retry.
- Programming is monotonic: a bit already 1 stays 1 regardless of wdata. Reprogramming the same word ORs new bits in.
- reset during PROG: pulse aborted, array word unchanged, FSM=IDLE, no wdone.
- Read of the word being programmed is impossible (ready=0).

Optional Feature:
- Macro OTPROM_WRITE_LOCK_EN.
- Defined: word DEPTH-1, bit 0 is the lock fuse. While it is 1, every accepted wen returns err (1 cycle after accept), does not enter PROG, and leaves the array unchanged. Programming the lock word itself completes normally, and lock takes effect from the next request. Reads are unaffected.
- Undefined: no lock logic; word DEPTH-1 is ordinary storage.

Test Plan:
- After reset, ren raddr=0x10 -> next cycle rvalid=1, rdata=0x00000000, err=0.
- wen waddr=0x10, wdata=0x0000_00F0 -> ready=0 for 9 cycles, wdone on cycle 9 after accept; then ren 0x10 -> rdata=0x000000F0.
- Second wen 0x10, wdata=0x0000_000F, then read -> 0x000000FF. Then wen with wdata=0 -> read still 0x000000FF (no 1->0).
- ren raddr=0x100 (DEPTH=64) -> rvalid=1, rdata=0, err=1. wen waddr=0x100 -> err pulse, ready stays 1, no wdone.
- Same-cycle ren 0x20 and wen 0x20 wdata=0x1 -> read returns 0x0; after wdone, read 0x20 returns 0x1. Assert reset 3 cycles into a separate wen to 0x24 -> no wdone; read 0x24 = 0.
- With OTPROM_WRITE_LOCK_EN: program 0xFC with 0x1, then wen 0x08 wdata=0xFF -> err=1, no wdone, read 0x08 = 0.
